// File: rtl/md_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_pkg
// Purpose  : Shared definitions for the MIPS E-stage multiply/divide unit:
//            MD operation codes, HI/LO pair type and an op-class helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package md_unit_pkg;

  typedef logic [3:0] md_op_t;

  localparam md_op_t MD_none  = 4'd0;
  localparam md_op_t MD_mult  = 4'd1;
  localparam md_op_t MD_multu = 4'd2;
  localparam md_op_t MD_div   = 4'd3;
  localparam md_op_t MD_divu  = 4'd4;
  localparam md_op_t MD_mthi  = 4'd5;
  localparam md_op_t MD_mtlo  = 4'd6;
  localparam md_op_t MD_mfhi  = 4'd7;
  localparam md_op_t MD_mflo  = 4'd8;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // Multi-cycle ops: these occupy the unit and must stall dependents in D.
  function automatic logic is_long_op(md_op_t op);
    return (op == MD_mult) || (op == MD_multu) ||
           (op == MD_div)  || (op == MD_divu);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_if
// Purpose  : Operation/result bundle between the E stage and md_unit.
// Signals  : md_op, a, b          -> operation and forwarded rs/rt
//            busy, md_stall       <- occupancy and hazard stall request
//            hi, lo, md_rdata     <- committed HI/LO and mfhi/mflo read data
// Modports : master (E-stage side), slave (md_unit side)
// Revision : 1.0  initial release
// ============================================================================
interface md_unit_if;
  import md_unit_pkg::*;

  md_op_t      md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_rdata;

  modport master (
    output md_op, a, b,
    input  busy, md_stall, hi, lo, md_rdata
  );

  modport slave (
    input  md_op, a, b,
    output busy, md_stall, hi, lo, md_rdata
  );

endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : Iterative multiply/divide unit owning HI/LO. The result is
//            computed at issue into a pending register and committed after
//            MULT_CYCLES / DIV_CYCLES busy cycles to model the latency.
// Ports    : clk   - clock, rising edge
//            reset - asynchronous, active-low
//            md    - md_unit_if.slave (op, operands, busy/stall, HI/LO, rdata)
// Revision : 1.0  initial release
// ============================================================================
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  hilo_t              pend_q;
  logic               pend_we_q;   // cleared for divide-by-zero: no commit

  hilo_t              mul_d;
  hilo_t              div_d;
  logic [31:0]        w_divisor;
  logic               w_ovf;

  always_comb begin
    mul_d = '0;
    if (md.md_op == MD_mult) begin
      mul_d = $signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b});
    end else begin
      mul_d = {32'd0, md.a} * {32'd0, md.b};
    end
  end

  // A zero divisor is replaced by 1 only to keep the operators well defined;
  // that result is never committed.
  assign w_divisor = (md.b == 32'd0) ? 32'd1 : md.b;
  assign w_ovf     = (md.a == 32'h8000_0000) && (md.b == 32'hFFFF_FFFF);

  always_comb begin
    div_d = '0;
    if (md.md_op == MD_div) begin
      if (w_ovf) begin
        div_d.lo = 32'h8000_0000;
        div_d.hi = 32'd0;
      end else begin
        div_d.lo = $signed(md.a) / $signed(w_divisor);
        div_d.hi = $signed(md.a) % $signed(w_divisor);
      end
    end else begin
      div_d.lo = md.a / w_divisor;
      div_d.hi = md.a % w_divisor;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_we_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          case (md.md_op)
            MD_mult, MD_multu: begin
              pend_q    <= mul_d;
              pend_we_q <= 1'b1;
              cnt_q     <= CNT_W'(MULT_CYCLES - 1);
              state_q   <= S_MUL;
            end
            MD_div, MD_divu: begin
              pend_q    <= div_d;
              pend_we_q <= (md.b != 32'd0);
              cnt_q     <= CNT_W'(DIV_CYCLES - 1);
              state_q   <= S_DIV;
            end
            MD_mthi: hi_q <= md.a;
            MD_mtlo: lo_q <= md.a;
            default: ;
          endcase
        end
        S_MUL, S_DIV: begin
          // Ops presented while busy are dropped; D is held via md_stall.
          if (cnt_q == '0) begin
            if (pend_we_q) begin
              hi_q <= pend_q.hi;
              lo_q <= pend_q.lo;
            end
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign md.busy     = (state_q != S_IDLE);
  assign md.md_stall = (state_q != S_IDLE) || is_long_op(md.md_op);
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.md_rdata = (md.md_op == MD_mfhi) ? hi_q :
                       (md.md_op == MD_mflo) ? lo_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Purpose  : Self-checking bench for md_unit. A reference model tracks HI/LO
//            and remaining busy cycles using 64-bit arithmetic; a compare
//            process checks all outputs every cycle, and directed vectors
//            pin hand-computed results.
// Revision : 1.0  initial release
// ============================================================================
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  bit   chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  md_unit_if u_if ();

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (rst_n),
    .md    (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pwe;
  int          m_left;            // busy cycles still to run
  longint      sa, sb, q, r, p;
  longint unsigned ua, ub, up;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_pwe = 0; m_phi = 0; m_plo = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && m_pwe) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else begin
      sa = $signed(u_if.a);
      sb = $signed(u_if.b);
      ua = {32'd0, u_if.a};
      ub = {32'd0, u_if.b};
      case (u_if.md_op)
        MD_mult:  begin p = sa * sb; m_phi = p[63:32]; m_plo = p[31:0]; m_pwe = 1; m_left = MULT_N; end
        MD_multu: begin up = ua * ub; m_phi = up[63:32]; m_plo = up[31:0]; m_pwe = 1; m_left = MULT_N; end
        MD_div: begin
          m_left = DIV_N;
          m_pwe  = (sb != 0);
          if (sb != 0) begin q = sa / sb; r = sa - q * sb; m_plo = q[31:0]; m_phi = r[31:0]; end
        end
        MD_divu: begin
          m_left = DIV_N;
          m_pwe  = (ub != 0);
          if (ub != 0) begin q = longint'(ua / ub); r = longint'(ua % ub); m_plo = q[31:0]; m_phi = r[31:0]; end
        end
        MD_mthi: m_hi = u_if.a;
        MD_mtlo: m_lo = u_if.a;
        default: ;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] exp_rd;
      logic        exp_st;
      exp_st = (m_left > 0) || (u_if.md_op inside {MD_mult, MD_multu, MD_div, MD_divu});
      exp_rd = (u_if.md_op == MD_mfhi) ? m_hi : (u_if.md_op == MD_mflo) ? m_lo : 32'd0;
      check("busy",     {31'd0, u_if.busy},     {31'd0, m_left > 0});
      check("md_stall", {31'd0, u_if.md_stall}, {31'd0, exp_st});
      check("hi",       u_if.hi,                m_hi);
      check("lo",       u_if.lo,                m_lo);
      check("md_rdata", u_if.md_rdata,          exp_rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input md_op_t op, input logic [31:0] aa, input logic [31:0] bb);
    u_if.md_op = op;
    u_if.a     = aa;
    u_if.b     = bb;
  endtask

  // Issue a long op for one cycle, then count busy cycles (bounded).
  task automatic run_long(input string nm, input md_op_t op, input logic [31:0] aa,
                          input logic [31:0] bb, input int exp_busy);
    int nb;
    drive(op, aa, bb);
    #1;
    check({nm, "_stall_issue"}, {31'd0, u_if.md_stall}, 32'd1);
    cyc();
    drive(MD_none, 32'd0, 32'd0);
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      if (!u_if.busy) break;
      nb++;
      cyc();
    end
    check({nm, "_busy_cycles"}, nb, exp_busy);
  endtask

  initial begin
    drive(MD_none, 32'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, u_if.busy}, 32'd0);
    check("rst_hi",   u_if.hi, 32'd0);
    check("rst_lo",   u_if.lo, 32'd0);
    chk_en = 1'b1;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    run_long("mult", MD_mult, 32'hFFFF_FFFD, 32'd7, MULT_N);
    check("mult_hi", u_if.hi, 32'hFFFF_FFFF);
    check("mult_lo", u_if.lo, 32'hFFFF_FFEB);

    run_long("multu", MD_multu, 32'hFFFF_FFFF, 32'd2, MULT_N);
    check("multu_hi", u_if.hi, 32'h0000_0001);
    check("multu_lo", u_if.lo, 32'hFFFF_FFFE);

    run_long("div", MD_div, 32'hFFFF_FFF9, 32'd2, DIV_N);
    check("div_lo", u_if.lo, 32'hFFFF_FFFD);
    check("div_hi", u_if.hi, 32'hFFFF_FFFF);

    run_long("divovf", MD_div, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N);
    check("divovf_lo", u_if.lo, 32'h8000_0000);
    check("divovf_hi", u_if.hi, 32'd0);

    drive(MD_mthi, 32'h11, 32'd0); cyc();
    drive(MD_mtlo, 32'h22, 32'd0); cyc();
    drive(MD_none, 32'd0, 32'd0);
    run_long("divz", MD_divu, 32'd7, 32'd0, DIV_N);
    check("divz_hi", u_if.hi, 32'h11);
    check("divz_lo", u_if.lo, 32'h22);

    drive(MD_mthi, 32'h1234, 32'd0); cyc();
    check("mthi_hi", u_if.hi, 32'h1234);
    drive(MD_mfhi, 32'd0, 32'd0); #1;
    check("mfhi_rd", u_if.md_rdata, 32'h1234);
    cyc();
    drive(MD_mflo, 32'd0, 32'd0); #1;
    check("mflo_rd", u_if.md_rdata, 32'h22);
    cyc();

    // mtlo held while mult is busy must be dropped
    drive(MD_mult, 32'd6, 32'd7); cyc();
    drive(MD_mtlo, 32'd5, 32'd0); cyc(); cyc(); cyc();
    drive(MD_none, 32'd0, 32'd0);
    for (int k = 0; k < 20 && u_if.busy; k++) cyc();
    check("ignbusy_lo", u_if.lo, 32'd42);
    check("ignbusy_hi", u_if.hi, 32'd0);

    // reset asserted in cycle 4 of a divide
    drive(MD_mthi, 32'h55, 32'd0); cyc();
    drive(MD_div, 32'd100, 32'd7); cyc();
    drive(MD_none, 32'd0, 32'd0);
    cyc(); cyc(); cyc();
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", {31'd0, u_if.busy}, 32'd0);
    check("rstmid_hi",   u_if.hi, 32'd0);
    check("rstmid_lo",   u_if.lo, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) cyc();
    check("rstmid_nocommit_hi", u_if.hi, 32'd0);
    check("rstmid_nocommit_lo", u_if.lo, 32'd0);
    check("rstmid_idle", {31'd0, u_if.busy}, 32'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
